fetch_buffer: RTL and testbench

//  Decoupling FIFO between fetch and decode. Accepts up to 4 fetched instructions per cycle.

---
 rtl/fetch_buffer_pkg.sv | 20 ++
 rtl/fetch_buffer_ram.sv | 41 ++++
 rtl/fetch_buffer.sv | 127 ++++++++++++
 tb/tb_fetch_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg
//   Shared types and sizing for the fetch buffer slice.
//   fb_entry_t pairs a PC with its instruction word; FB_DEPTH / FB_PTR_W give
//   the default storage depth and pointer width.
package fetch_buffer_pkg;

  localparam int unsigned FB_DEPTH = 16;
  localparam int unsigned FB_PTR_W = $clog2(FB_DEPTH);
  localparam int unsigned FB_LANES = 4;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] inst_t;
  typedef logic        bool_t;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } fb_entry_t;

endpackage

// File: rtl/fetch_buffer_ram.sv
// fb_ram
//   DEPTH x fb_entry_t register array, NW write ports, NR asynchronous read
//   ports. Data is never reset; the owner guarantees distinct write addresses.
// Ports
//   clk    in   write clock
//   we     in   per-port write enable
//   waddr  in   per-port write address
//   wdata  in   per-port write data
//   raddr  in   per-port read address
//   rdata  out  per-port read data (combinational)
module fb_ram
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned NW    = FB_LANES,
  parameter int unsigned NR    = FB_LANES
) (
  input  logic                      clk,
  input  logic [NW-1:0]             we,
  input  logic [NW-1:0][PTR_W-1:0]  waddr,
  input  fb_entry_t [NW-1:0]        wdata,
  input  logic [NR-1:0][PTR_W-1:0]  raddr,
  output fb_entry_t [NR-1:0]        rdata
);

  fb_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NW; i++) begin
      if (we[i]) mem[waddr[i]] <= wdata[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      rdata[i] = mem[raddr[i]];
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Decoupling FIFO between fetch and decode. Accepts an all-or-nothing group
//   of up to PUSH_W instructions per cycle and presents the oldest POP_W in
//   program order; decode retires 0..POP_W per cycle. flush empties it.
//   Optional macro FETCH_BUFFER_BYPASS_EN: when empty (and not flushing) the
//   push lanes drive the outputs in the same cycle.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                discard all contents
//   push_num/pc/inst     offered group, lane 0 oldest
//   push_accept          group written this cycle
//   fb_free              free entries at start of cycle
//   out_num/pc/inst      presented lanes, lane 0 = head; unused lanes are 0
//   pop_num              lanes consumed by decode (clipped to out_num)
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = FB_DEPTH,
  parameter int unsigned PUSH_W = FB_LANES,
  parameter int unsigned POP_W  = FB_LANES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [2:0]               push_num,
  input  logic [PUSH_W*32-1:0]     push_pc,
  input  logic [PUSH_W*32-1:0]     push_inst,
  output logic                     push_accept,
  output logic [$clog2(DEPTH):0]   fb_free,
  output logic [2:0]               out_num,
  output logic [POP_W*32-1:0]      out_pc,
  output logic [POP_W*32-1:0]      out_inst,
  input  logic [2:0]               pop_num
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  bool_t      bypass;
  logic [2:0] pop_eff;
  logic [2:0] skip;

  logic [PUSH_W-1:0]             we;
  logic [PUSH_W-1:0][PTR_W-1:0]  waddr;
  fb_entry_t [PUSH_W-1:0]        wdata;
  logic [POP_W-1:0][PTR_W-1:0]   raddr;
  fb_entry_t [POP_W-1:0]         rdata;

  fb_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .NW    (PUSH_W),
    .NR    (POP_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    fb_free     = CNT_W'(DEPTH) - count_q;
    push_accept = (push_num != 3'd0) && (CNT_W'(push_num) <= fb_free) && !flush;

`ifdef FETCH_BUFFER_BYPASS_EN
    bypass = (count_q == '0) && !flush;
`else
    bypass = 1'b0;
`endif

    if (bypass)                           out_num = push_num;
    else if (count_q >= CNT_W'(POP_W))    out_num = 3'(POP_W);
    else                                  out_num = 3'(count_q);

    pop_eff = (pop_num < out_num) ? pop_num : out_num;

    // In bypass the lanes decode consumes this cycle never reach storage;
    // the survivors are packed down to start at tail.
    skip = bypass ? pop_eff : 3'd0;

    for (int unsigned i = 0; i < PUSH_W; i++) begin
      we[i]         = push_accept && (3'(i) < push_num) && (3'(i) >= skip);
      waddr[i]      = tail_q + PTR_W'(i) - PTR_W'(skip);
      wdata[i].pc   = push_pc[i*32 +: 32];
      wdata[i].inst = push_inst[i*32 +: 32];
    end

    out_pc   = '0;
    out_inst = '0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      raddr[i] = head_q + PTR_W'(i);
      if (3'(i) < out_num) begin
        out_pc[i*32 +: 32]   = bypass ? push_pc[i*32 +: 32]   : rdata[i].pc;
        out_inst[i*32 +: 32] = bypass ? push_inst[i*32 +: 32] : rdata[i].inst;
      end
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = bypass ? head_q : head_q + PTR_W'(pop_eff);
      tail_d  = push_accept ? tail_q + PTR_W'(push_num) - PTR_W'(skip) : tail_q;
      count_d = count_q + (push_accept ? CNT_W'(push_num) : '0) - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   push_num = '0;
  logic [127:0] push_pc = '0;
  logic [127:0] push_inst = '0;
  logic         push_accept;
  logic [4:0]   fb_free;
  logic [2:0]   out_num;
  logic [127:0] out_pc;
  logic [127:0] out_inst;
  logic [2:0]   pop_num = '0;

  logic [63:0] mq[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .push_num    (push_num),
    .push_pc     (push_pc),
    .push_inst   (push_inst),
    .push_accept (push_accept),
    .fb_free     (fb_free),
    .out_num     (out_num),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .pop_num     (pop_num)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] lane(logic [127:0] v, int i);
    return v[i*32 +: 32];
  endfunction

  // Model: queue of {pc,inst}; expected outputs derived from its size/contents.
  task automatic check_cycle();
    int cnt, free, on, pe;
    bit byp, acc;
    logic [31:0] e_pc, e_inst;
    cnt  = mq.size();
    free = 16 - cnt;
    byp  = BYP && (cnt == 0) && !flush;
    acc  = (push_num != 0) && (int'(push_num) <= free) && !flush;
    on   = byp ? int'(push_num) : ((cnt < 4) ? cnt : 4);
    chk("fb_free", 32'(fb_free), 32'(free));
    chk("push_accept", 32'(push_accept), 32'(acc));
    chk("out_num", 32'(out_num), 32'(on));
    for (int i = 0; i < 4; i++) begin
      e_pc = '0;
      e_inst = '0;
      if (i < on) begin
        e_pc   = byp ? lane(push_pc, i)   : mq[i][63:32];
        e_inst = byp ? lane(push_inst, i) : mq[i][31:0];
      end
      chk($sformatf("out_pc[%0d]", i), lane(out_pc, i), e_pc);
      chk($sformatf("out_inst[%0d]", i), lane(out_inst, i), e_inst);
    end
    pe = (int'(pop_num) < on) ? int'(pop_num) : on;
    if (flush) mq.delete();
    else begin
      if (acc)
        for (int i = 0; i < int'(push_num); i++)
          mq.push_back({lane(push_pc, i), lane(push_inst, i)});
      repeat (pe) void'(mq.pop_front());
    end
  endtask

  task automatic drive(input bit fl, input int pn, input int popn, input logic [31:0] pcb);
    @(negedge clk);
    flush    = fl;
    push_num = 3'(pn);
    pop_num  = 3'(popn);
    for (int i = 0; i < 4; i++) begin
      push_pc[i*32 +: 32]   = pcb + 32'(4 * i);
      push_inst[i*32 +: 32] = $urandom;
    end
    #1;
    check_cycle();
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_out_num", 32'(out_num), 32'd0);
    chk("rst_fb_free", 32'(fb_free), 32'd16);
    chk("rst_push_accept", 32'(push_accept), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Push 4, visible next cycle
    drive(0, 4, 0, 32'h100);
    chk("t2_accept", 32'(push_accept), 32'd1);
    drive(0, 0, 0, 32'h0);
    chk("t2_out_num", 32'(out_num), 32'd4);
    chk("t2_lane0", lane(out_pc, 0), 32'h100);
    chk("t2_lane3", lane(out_pc, 3), 32'h10C);
    chk("t2_fb_free", 32'(fb_free), 32'd12);

    // Fill to 14, reject 3, accept 2
    drive(0, 4, 0, 32'h200);
    drive(0, 4, 0, 32'h300);
    drive(0, 2, 0, 32'h400);
    drive(0, 3, 0, 32'h500);
    chk("t3_reject", 32'(push_accept), 32'd0);
    chk("t3_free14", 32'(fb_free), 32'd2);
    drive(0, 2, 0, 32'h600);
    chk("t3_accept2", 32'(push_accept), 32'd1);
    drive(0, 0, 0, 32'h0);
    chk("t3_full", 32'(fb_free), 32'd0);

    // Full: push rejected, pop proceeds; pop clipping
    drive(0, 1, 4, 32'h700);
    chk("t5_reject", 32'(push_accept), 32'd0);
    drive(0, 0, 0, 32'h0);
    chk("t5_free", 32'(fb_free), 32'd4);
    drive(0, 0, 4, 32'h0);
    drive(0, 0, 4, 32'h0);
    drive(0, 0, 2, 32'h0);
    drive(0, 0, 4, 32'h0);
    chk("t5_out2", 32'(out_num), 32'd2);
    drive(0, 0, 0, 32'h0);
    chk("t5_empty", 32'(out_num), 32'd0);
    chk("t5_free16", 32'(fb_free), 32'd16);

    // Wrap: head=14 with 6 entries
    drive(1, 0, 0, 32'h0);
    drive(0, 4, 0, 32'h1000);
    drive(0, 4, 0, 32'h1010);
    drive(0, 4, 0, 32'h1020);
    drive(0, 2, 0, 32'h1030);
    drive(0, 0, 4, 32'h0);
    drive(0, 0, 4, 32'h0);
    drive(0, 0, 4, 32'h0);
    drive(0, 0, 2, 32'h0);
    drive(0, 4, 0, 32'h2000);
    drive(0, 2, 0, 32'h3000);
    drive(0, 0, 4, 32'h0);
    chk("t4_lane0", lane(out_pc, 0), 32'h2000);
    chk("t4_lane1", lane(out_pc, 1), 32'h2004);
    chk("t4_lane2", lane(out_pc, 2), 32'h2008);
    chk("t4_lane3", lane(out_pc, 3), 32'h200C);
    drive(0, 0, 0, 32'h0);
    chk("t4_out_num", 32'(out_num), 32'd2);
    chk("t4_after_pc0", lane(out_pc, 0), 32'h3000);
    chk("t4_after_pc1", lane(out_pc, 1), 32'h3004);

    // Flush beats same-cycle push and pop
    drive(1, 4, 2, 32'h4000);
    chk("t6_accept", 32'(push_accept), 32'd0);
    drive(0, 0, 0, 32'h0);
    chk("t6_out_num", 32'(out_num), 32'd0);
    chk("t6_free", 32'(fb_free), 32'd16);

`ifdef FETCH_BUFFER_BYPASS_EN
    drive(0, 3, 1, 32'h500);
    chk("byp_out_num", 32'(out_num), 32'd3);
    chk("byp_lane0", lane(out_pc, 0), 32'h500);
    drive(0, 0, 0, 32'h0);
    chk("byp_free", 32'(fb_free), 32'd14);
    chk("byp_lane0_next", lane(out_pc, 0), 32'h504);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 31) == 0,
            int'($urandom_range(0, 4)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 3)),
            $urandom & 32'hFFFF_FFFC);
    end

    // Asynchronous reset mid-traffic with 7 entries
    drive(1, 0, 0, 32'h0);
    drive(0, 4, 0, 32'h8000);
    drive(0, 3, 0, 32'h9000);
    drive(0, 0, 0, 32'h0);
    chk("t1_pre_free", 32'(fb_free), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_out_num", 32'(out_num), 32'd0);
    chk("t1_fb_free", 32'(fb_free), 32'd16);
    chk("t1_accept", 32'(push_accept), 32'd0);
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 2, 0, 32'hA000);
    drive(0, 0, 0, 32'h0);
    chk("t1_post_pc", lane(out_pc, 1), 32'hA004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
